// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM breathing sequencer.
package pwm_ctrl_pkg;

  localparam int unsigned STEP_W_DEF = 24;
  localparam int unsigned CYC_W_DEF  = 8;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned DUTY_W     = 7;
  localparam int unsigned DUTY_FULL  = 100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_e;

  // Clamp a requested peak duty to the full-scale value.
  function automatic logic [DUTY_W-1:0] clamp_peak(input logic [DUTY_W-1:0] peak);
    return (peak > DUTY_W'(DUTY_FULL)) ? DUTY_W'(DUTY_FULL) : peak;
  endfunction

endpackage

// File: rtl/pwm_breath_ctrl_if.sv
// Configuration/request inputs and PWM-drive outputs of the breathing sequencer.
interface pwm_breath_ctrl_if
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = STEP_W_DEF,
  parameter int unsigned CYC_W  = CYC_W_DEF
);

  logic              start;
  logic              stop;
  logic [DIV_W-1:0]  cfg_div;
  logic [DUTY_W-1:0] cfg_peak;
  logic [STEP_W-1:0] cfg_step;
  logic [STEP_W-1:0] cfg_hold_hi;
  logic [STEP_W-1:0] cfg_hold_lo;
  logic [CYC_W-1:0]  cfg_cycles;

  logic              pwm_en;
  logic [DIV_W-1:0]  pwm_div;
  logic [DUTY_W-1:0] pwm_duty;
  logic              busy;
  logic              done;

  // Requester side: drives requests and config, observes the PWM drive.
  modport master (
    output start, stop, cfg_div, cfg_peak, cfg_step, cfg_hold_hi, cfg_hold_lo, cfg_cycles,
    input  pwm_en, pwm_div, pwm_duty, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, stop, cfg_div, cfg_peak, cfg_step, cfg_hold_hi, cfg_hold_lo, cfg_cycles,
    output pwm_en, pwm_div, pwm_duty, busy, done
  );

endinterface

// File: rtl/pwm_step_timer.sv
// Shared period timer: counts 0..period-1 while enabled and flags the last count.
module pwm_step_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [STEP_W-1:0] i_period,
  output logic              o_tc_c
);

  logic [STEP_W-1:0] r_cnt;
  logic              w_last;

  // Last count when cnt+1 reaches the period; a zero period is always "last".
  always_comb begin
    w_last = (({1'b0, r_cnt} + (STEP_W+1)'(1)) >= {1'b0, i_period});
    o_tc_c = i_en & w_last;
  end

  // Counter register: clear wins, wraps to 0 at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : (r_cnt + STEP_W'(1));
    end
  end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-duty sequencer that owns the enable/divider/duty inputs of one PWM generator.
module pwm_breath_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = STEP_W_DEF,
  parameter int unsigned CYC_W  = CYC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_breath_ctrl_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;

  logic              r_en,       w_en_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_done,     w_done_nxt;
  logic [DIV_W-1:0]  r_div,      w_div_nxt;
  logic [DUTY_W-1:0] r_duty,     w_duty_nxt;
  logic [DUTY_W-1:0] r_peak,     w_peak_nxt;
  logic [STEP_W-1:0] r_step,     w_step_nxt;
  logic [STEP_W-1:0] r_hold_hi,  w_hold_hi_nxt;
  logic [STEP_W-1:0] r_hold_lo,  w_hold_lo_nxt;
  logic [CYC_W-1:0]  r_cycles,   w_cycles_nxt;
  logic [CYC_W-1:0]  r_breaths,  w_breaths_nxt;
  logic [CYC_W-1:0]  w_breaths_inc;
  logic              r_stop_pend, w_stop_pend_nxt;
  logic              w_stop;

  logic              w_tmr_clr;
  logic              w_tmr_en;
  logic [STEP_W-1:0] w_tmr_period;
  logic              w_tc;

  // One timer serves both the duty step period and the hold waits.
  pwm_step_timer #(
    .STEP_W (STEP_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .i_period (w_tmr_period),
    .o_tc_c   (w_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, next-output and timer control.
  always_comb begin
    w_state_nxt     = r_state;
    w_en_nxt        = r_en;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_div_nxt       = r_div;
    w_duty_nxt      = r_duty;
    w_peak_nxt      = r_peak;
    w_step_nxt      = r_step;
    w_hold_hi_nxt   = r_hold_hi;
    w_hold_lo_nxt   = r_hold_lo;
    w_cycles_nxt    = r_cycles;
    w_breaths_nxt   = r_breaths;
    w_breaths_inc   = (r_breaths == '1) ? r_breaths : (r_breaths + CYC_W'(1));
    w_stop_pend_nxt = r_stop_pend | (bus.stop & (r_state != ST_IDLE));
    w_stop          = bus.stop | r_stop_pend;
    w_tmr_en        = 1'b0;
    w_tmr_period    = r_step;

    case (r_state)
      ST_IDLE: begin
        w_stop_pend_nxt = 1'b0;
        if (bus.start && !bus.stop) begin
          w_state_nxt   = ST_RISE;
          w_en_nxt      = 1'b1;
          w_busy_nxt    = 1'b1;
          w_duty_nxt    = '0;
          w_breaths_nxt = '0;
          w_div_nxt     = (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div;
          w_peak_nxt    = clamp_peak(bus.cfg_peak);
          w_step_nxt    = (bus.cfg_step == '0) ? STEP_W'(1) : bus.cfg_step;
          w_hold_hi_nxt = bus.cfg_hold_hi;
          w_hold_lo_nxt = bus.cfg_hold_lo;
          w_cycles_nxt  = bus.cfg_cycles;
        end
      end

      ST_RISE: begin
        w_tmr_en     = 1'b1;
        w_tmr_period = r_step;
        if (w_stop) begin
          w_state_nxt = ST_FALL;
        end else if (r_duty >= r_peak) begin
          w_state_nxt = ST_HOLD_HI;
        end else if (w_tc) begin
          w_duty_nxt = r_duty + DUTY_W'(1);
        end
      end

      ST_HOLD_HI: begin
        w_tmr_en     = 1'b1;
        w_tmr_period = r_hold_hi;
        if (w_stop || w_tc) begin
          w_state_nxt = ST_FALL;
        end
      end

      ST_FALL: begin
        w_tmr_en     = 1'b1;
        w_tmr_period = r_step;
        if (r_duty == '0) begin
          w_state_nxt = ST_HOLD_LO;
        end else if (w_tc) begin
          w_duty_nxt = r_duty - DUTY_W'(1);
          if (r_duty == DUTY_W'(1)) begin
            w_state_nxt = ST_HOLD_LO;
          end
        end
      end

      ST_HOLD_LO: begin
        w_tmr_en     = 1'b1;
        w_tmr_period = r_hold_lo;
        if (w_tc) begin
          w_breaths_nxt = w_breaths_inc;
          if (((r_cycles != '0) && (w_breaths_inc == r_cycles)) || w_stop) begin
            w_state_nxt     = ST_IDLE;
            w_en_nxt        = 1'b0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
            w_duty_nxt      = '0;
            w_stop_pend_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_RISE;
          end
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_en_nxt        = 1'b0;
        w_busy_nxt      = 1'b0;
        w_duty_nxt      = '0;
        w_stop_pend_nxt = 1'b0;
      end
    endcase

    w_tmr_clr = (w_state_nxt != r_state);
  end

  // Registered outputs, latched configuration and sequence counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div       <= '0;
      r_duty      <= '0;
      r_peak      <= '0;
      r_step      <= '0;
      r_hold_hi   <= '0;
      r_hold_lo   <= '0;
      r_cycles    <= '0;
      r_breaths   <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_en        <= w_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_div       <= w_div_nxt;
      r_duty      <= w_duty_nxt;
      r_peak      <= w_peak_nxt;
      r_step      <= w_step_nxt;
      r_hold_hi   <= w_hold_hi_nxt;
      r_hold_lo   <= w_hold_lo_nxt;
      r_cycles    <= w_cycles_nxt;
      r_breaths   <= w_breaths_nxt;
      r_stop_pend <= w_stop_pend_nxt;
    end
  end

  // Drive the PWM generator straight from registers.
  assign bus.pwm_en   = r_en;
  assign bus.pwm_div  = r_div;
  assign bus.pwm_duty = r_duty;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Directed bench for the breathing sequencer with a simple PWM generator model.
module tb_pwm_breath_ctrl;
  import pwm_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pwm_breath_ctrl_if u_if ();

  pwm_breath_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  // Reference PWM generator: period 100 duty slots, each slot pwm_div clocks.
  int   pwm_pre = 0;
  int   pwm_cnt = 0;
  logic pwm_o;
  always @(posedge clk) begin
    if (!u_if.pwm_en) begin
      pwm_pre <= 0;
      pwm_cnt <= 0;
    end else if (pwm_pre + 1 >= int'(u_if.pwm_div)) begin
      pwm_pre <= 0;
      pwm_cnt <= (pwm_cnt == 99) ? 0 : pwm_cnt + 1;
    end else begin
      pwm_pre <= pwm_pre + 1;
    end
  end
  assign pwm_o = (pwm_cnt < int'(u_if.pwm_duty));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int div, input int peak, input int step,
                         input int hh, input int hl, input int cyc);
    u_if.cfg_div     = 16'(div);
    u_if.cfg_peak    = 7'(peak);
    u_if.cfg_step    = 24'(step);
    u_if.cfg_hold_hi = 24'(hh);
    u_if.cfg_hold_lo = 24'(hl);
    u_if.cfg_cycles  = 8'(cyc);
  endtask

  task automatic pulse_start();
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
  endtask

  task automatic pulse_stop();
    u_if.stop = 1'b1;
    tick();
    u_if.stop = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!u_if.done && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_duty(input int target, input int max, output int n);
    n = 0;
    while (int'(u_if.pwm_duty) != target && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_en"},   u_if.pwm_en,   0);
    chk({tag, "_div"},  u_if.pwm_div,  0);
    chk({tag, "_duty"}, u_if.pwm_duty, 0);
    chk({tag, "_busy"}, u_if.busy,     0);
    chk({tag, "_done"}, u_if.done,     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, busy_cnt, bad, dn, hi, prev, rose, en_drop;
    int exp1[29] = '{0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,4,4,4,3,3,3,2,2,2,1,1,1,0,0};

    u_if.start = 1'b0;
    u_if.stop  = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);

    // Reset state
    tick();
    tick();
    chk_idle_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Single breath trace: div=10 peak=4 step=3 holds=2 cycles=1
    set_cfg(10, 4, 3, 2, 2, 1);
    pulse_start();
    chk("t1_en", u_if.pwm_en, 1);
    chk("t1_div", u_if.pwm_div, 10);
    busy_cnt = 0;
    for (int i = 0; i < 29; i++) begin
      chk($sformatf("t1_duty[%0d]", i), u_if.pwm_duty, exp1[i]);
      if (u_if.busy) busy_cnt++;
      tick();
    end
    chk("t1_busy_cycles", busy_cnt, 29);
    chk("t1_done", u_if.done, 1);
    chk("t1_busy_end", u_if.busy, 0);
    chk("t1_en_end", u_if.pwm_en, 0);
    chk("t1_duty_end", u_if.pwm_duty, 0);
    tick();
    chk("t1_done_pulse", u_if.done, 0);

    // Peak clamp and zero step: one duty unit per clock up to 100
    set_cfg(1, 120, 0, 5, 0, 1);
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (i == 50) chk("t2_duty_mid", u_if.pwm_duty, 50);
      tick();
    end
    chk("t2_duty_100", u_if.pwm_duty, 100);
    tick();
    tick();
    chk("t2_duty_clamped", u_if.pwm_duty, 100);
    pulse_stop();
    wait_done(300, n);
    chk("t2_done", u_if.done, 1);
    chk("t2_fall_cycles", n, 101);

    // peak=0, zero holds, three breaths
    set_cfg(3, 0, 2, 0, 0, 3);
    pulse_start();
    busy_cnt = 0; bad = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (u_if.busy) busy_cnt++;
      if (u_if.pwm_duty != 0) bad++;
      if (u_if.done) dn++;
      tick();
    end
    chk("t3_busy_cycles", busy_cnt, 12);
    chk("t3_duty_nonzero", bad, 0);
    chk("t3_done_pulses", dn, 1);

    // Infinite mode, stop at duty 20, start and config changes ignored while busy
    set_cfg(5, 30, 2, 4, 4, 0);
    pulse_start();
    wait_duty(20, 100, n);
    chk("t4_rise_time", n, 40);
    u_if.stop    = 1'b1;
    u_if.start   = 1'b1;
    u_if.cfg_div = 16'd77;
    u_if.cfg_peak = 7'd3;
    tick();
    u_if.stop  = 1'b0;
    u_if.start = 1'b0;
    chk("t4_duty_hold", u_if.pwm_duty, 20);
    chk("t4_div_kept", u_if.pwm_div, 5);
    n = 0; rose = 0; en_drop = 0;
    prev = int'(u_if.pwm_duty);
    while (!u_if.done && n < 200) begin
      if (int'(u_if.pwm_duty) > prev) rose++;
      if (!u_if.pwm_en) en_drop++;
      prev = int'(u_if.pwm_duty);
      tick();
      n++;
    end
    chk("t4_stop_to_done", n, 44);
    chk("t4_duty_rose", rose, 0);
    chk("t4_en_early_drop", en_drop, 0);
    chk("t4_done_duty", u_if.pwm_duty, 0);
    chk("t4_done_en", u_if.pwm_en, 0);
    tick();
    set_cfg(4, 10, 1, 0, 0, 1);
    u_if.start = 1'b1;
    u_if.stop  = 1'b1;
    tick();
    u_if.start = 1'b0;
    u_if.stop  = 1'b0;
    chk("t4_startstop_busy", u_if.busy, 0);
    chk("t4_startstop_en", u_if.pwm_en, 0);
    tick();
    chk("t4_startstop_busy2", u_if.busy, 0);

    // Asynchronous reset mid-rise, then a clean restart
    set_cfg(2, 50, 1, 0, 0, 0);
    pulse_start();
    repeat (37) tick();
    chk("t5_duty_37", u_if.pwm_duty, 37);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t5_async");
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_busy_after", u_if.busy, 0);
    chk("t5_duty_after", u_if.pwm_duty, 0);
    set_cfg(3, 2, 1, 1, 1, 1);
    pulse_start();
    chk("t5_restart_busy", u_if.busy, 1);
    chk("t5_restart_div", u_if.pwm_div, 3);
    wait_done(50, n);
    chk("t5_restart_done", u_if.done, 1);
    chk("t5_restart_len", n, 7);

    // 50 % duty held at peak gives 50 high clocks of every 100
    set_cfg(1, 50, 1, 300, 0, 1);
    pulse_start();
    wait_duty(50, 100, n);
    chk("t6_rise_time", n, 50);
    tick();
    tick();
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pwm_o) hi++;
    end
    chk("t6_pwm_high", hi, 50);
    pulse_stop();
    wait_done(200, n);
    chk("t6_done", u_if.done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_breath_ctrl.md
Name: pwm_breath_ctrl

Overview:
Sequencer that drives the configuration inputs (enable, divider, duty) of one PWM generator instance. It produces "breathing" waveforms: duty ramps 0 -> peak, holds, ramps peak -> 0, holds, and repeats for a programmed number of breaths or indefinitely. It sits between the register/button logic and the PWM block, and owns pwm_en, pwm_div and pwm_duty exclusively.

Parameters:
STEP_W, 24, width of step-period and hold counters (clock cycles)
CYC_W, 8, width of breath-count config and counter
DUTY_FULL, 100, duty value meaning 100 % (PWM duty counter spans 0..99)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  one-cycle request to begin a sequence; honoured only in IDLE
stop  in  1  one-cycle request for graceful termination
cfg_div  in  16  PWM divider; latched on accepted start
cfg_peak  in  7  peak duty 0..100; latched; values >100 clamp to 100
cfg_step  in  STEP_W  clocks per 1-unit duty step; latched; 0 treated as 1
cfg_hold_hi  in  STEP_W  clocks held at peak; latched; 0 = no hold
cfg_hold_lo  in  STEP_W  clocks held at 0; latched; 0 = no hold
cfg_cycles  in  CYC_W  number of breaths; latched; 0 = run until stop
pwm_en  out  1  enable to PWM generator
pwm_div  out  16  divider to PWM generator
pwm_duty  out  7  duty to PWM generator
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; pwm_en=0, pwm_div=0, pwm_duty=0, busy=0, done=0; all counters and latched config cleared. Deassertion mid-sequence restarts cleanly from IDLE.
- All outputs registered; no combinational path from inputs to outputs.
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
- IDLE: start=1 and stop=0 at edge N -> config latched, pwm_div = max(cfg_div,1), duty=0, breath count=0, state RISE; pwm_en=busy=1 visible after edge N. start and stop together in IDLE: stop wins, nothing happens.
- RISE: step timer counts 0..step-1; at terminal count duty += 1 and timer clears. First increment occurs step clocks after entering RISE. When duty == peak (checked every cycle, including on entry), go to HOLD_HI. peak=0 -> HOLD_HI on the cycle after entry.
- HOLD_HI: wait hold_hi clocks, then FALL; hold_hi=0 -> FALL next cycle.
- FALL: duty -= 1 per step period; duty == 0 -> HOLD_LO. Duty never underflows or exceeds peak.
- HOLD_LO: wait hold_lo clocks; then breath count += 1. If (cycles != 0 and count == cycles) or stop pending -> IDLE with done=1 for one cycle, pwm_en=0, duty=0; otherwise -> RISE.
- stop while busy sets a sticky stop_pending flag (cleared on entry to IDLE): RISE or HOLD_HI goes to FALL on the next cycle from current duty; FALL continues; HOLD_LO finishes its hold then exits. Duty therefore always returns to 0 before pwm_en drops.
- start while busy: ignored. Config input changes while busy: ignored.
- Breath counter saturates at 2^CYC_W-1 in infinite mode (no wrap side effects).
- Timers reset to 0 on every state transition.

Decomposition:
- Package pwm_ctrl_pkg: state enum (IDLE, RISE, HOLD_HI, FALL, HOLD_LO), DUTY_FULL constant, STEP_W/CYC_W defaults.
- One sub-module pwm_step_timer: STEP_W-bit counter with clear, enable, period input, and a terminal-count pulse output; one instance serves both the step period and the hold wait (the period is muxed by state).

Test Plan:
- Reset mid-RISE with duty=37 -> all outputs 0 immediately (async), IDLE after release; start then works normally.
- div=10, peak=4, step=3, holds=2, cycles=1 -> duty 0,1,2,3,4 each 3 clocks, 4 for 2 clocks, 4->0 down, 0 for 2 clocks, done pulse, pwm_en=0; total busy time 3*4+1+2+3*4+2 ±1 checked exactly.
- peak=120, step=0 -> clamp to 100, duty increments every clock, reaches 100 in 100 clocks.
- peak=0, holds=0, cycles=3 -> duty stays 0; exactly 3 passes through the states, then done.
- cycles=0, stop asserted in RISE at duty=20 -> FALL next cycle, duty 20->0, HOLD_LO, done, IDLE; a start during the sequence ignored; start+stop together in IDLE ignored.
- Connect to PWM generator: peak=50, div=1 at HOLD_HI -> measured pwm output high 50 of 100 clocks.
